serial_bit_feeder: RTL and testbench



---
 rtl/serial_bit_feeder_if.sv | 30 +++
 rtl/serial_bit_feeder.sv | 97 +++++++++
 tb/tb_serial_bit_feeder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/serial_bit_feeder_if.sv
// Handshake and serial-output bundle between an upstream word source and the
// bit feeder that drives the pattern detector's x input.
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             x_out;
    logic             x_valid;
    logic             last_bit;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  x_out,
        input  x_valid,
        input  last_bit
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output x_out,
        output x_valid,
        output last_bit
    );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end for the serial pattern detector: loads WIDTH-bit
// words over valid/ready and emits them one bit per clock with zero inter-word gap.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic                CLK,
    input  logic                RESET,
    serial_bit_feeder_if.slave  bus
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = '0;

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             x_out_q;
    logic             x_out_next;
    logic             x_valid_q;
    logic             x_valid_next;
    logic             load_ready_w;
    logic             accept;
    logic             load_first_bit;
    logic [WIDTH-1:0] load_rest;
    logic             shift_bit;
    logic [WIDTH-1:0] shift_rest;

    // Ready while idle or while the last bit of the current word is on x_out,
    // which is what lets a new word follow without a gap.
    assign load_ready_w = !RESET && ((cnt == CNT_ZERO) || (cnt == CNT_ONE));
    assign accept       = bus.load_valid && load_ready_w;

    always_comb begin
        load_first_bit = 1'b0;
        load_rest      = '0;
        shift_bit      = 1'b0;
        shift_rest     = '0;
        if (MSB_FIRST) begin
            load_first_bit = bus.load_data[WIDTH-1];
            load_rest      = {bus.load_data[WIDTH-2:0], 1'b0};
            shift_bit      = shreg[WIDTH-1];
            shift_rest     = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            load_first_bit = bus.load_data[0];
            load_rest      = {1'b0, bus.load_data[WIDTH-1:1]};
            shift_bit      = shreg[0];
            shift_rest     = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    always_comb begin
        shreg_next   = shreg;
        cnt_next     = cnt;
        x_out_next   = x_out_q;
        x_valid_next = x_valid_q;
        if (accept) begin
            x_out_next   = load_first_bit;
            shreg_next   = load_rest;
            cnt_next     = CNT_FULL;
            x_valid_next = 1'b1;
        end else if (cnt > CNT_ONE) begin
            x_out_next   = shift_bit;
            shreg_next   = shift_rest;
            cnt_next     = cnt - CNT_ONE;
        end else if (cnt == CNT_ONE) begin
            x_out_next   = IDLE_BIT;
            x_valid_next = 1'b0;
            cnt_next     = CNT_ZERO;
        end
    end

    // Reset drops any word in flight outright.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shreg     <= '0;
            cnt       <= CNT_ZERO;
            x_out_q   <= IDLE_BIT;
            x_valid_q <= 1'b0;
        end else begin
            shreg     <= shreg_next;
            cnt       <= cnt_next;
            x_out_q   <= x_out_next;
            x_valid_q <= x_valid_next;
        end
    end

    assign bus.load_ready = load_ready_w;
    assign bus.x_out      = x_out_q;
    assign bus.x_valid    = x_valid_q;
    assign bus.last_bit   = x_valid_q && (cnt == CNT_ONE);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: an 8-bit MSB-first lane, an 8-bit
// LSB-first lane with IDLE_BIT=1, and a 2-bit lane, sharing one clock and reset.
module tb_serial_bit_feeder;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    serial_bit_feeder_if #(.WIDTH(8)) bus8 ();
    serial_bit_feeder_if #(.WIDTH(8)) bus_lsb ();
    serial_bit_feeder_if #(.WIDTH(2)) bus2 ();

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut8 (
        .CLK(CLK), .RESET(RESET), .bus(bus8.slave)
    );
    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
        .CLK(CLK), .RESET(RESET), .bus(bus_lsb.slave)
    );
    serial_bit_feeder #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut2 (
        .CLK(CLK), .RESET(RESET), .bus(bus2.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data);
        bus8.load_valid = valid;
        bus8.load_data  = data;
    endtask

    initial begin
        logic [7:0]  word;
        logic [7:0]  intruder;
        logic [15:0] stream;
        logic [3:0]  stream2;

        checks = 0;
        errors = 0;
        RESET  = 1'b1;
        applyStimulus(1'b0, 8'h00);
        bus_lsb.load_valid = 1'b0;
        bus_lsb.load_data  = 8'h00;
        bus2.load_valid    = 1'b0;
        bus2.load_data     = 2'b00;

        repeat (2) @(negedge CLK);
        checkOutput("reset_ready", 32'(bus8.load_ready), 32'd0);
        checkOutput("reset_xvalid", 32'(bus8.x_valid), 32'd0);
        checkOutput("reset_xout", 32'(bus8.x_out), 32'd0);
        checkOutput("reset_lsb_xout", 32'(bus_lsb.x_out), 32'd1);
        RESET = 1'b0;
        #1;
        checkOutput("idle_ready", 32'(bus8.load_ready), 32'd1);

        // Single MSB-first word 8'hD0.
        word = 8'hD0;
        applyStimulus(1'b1, word);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (i == 0) applyStimulus(1'b0, 8'h00);
            checkOutput($sformatf("d0_bit%0d", i), 32'(bus8.x_out), 32'(word[7-i]));
            checkOutput($sformatf("d0_valid%0d", i), 32'(bus8.x_valid), 32'd1);
            checkOutput($sformatf("d0_last%0d", i), 32'(bus8.last_bit), 32'(i == 7));
        end
        @(negedge CLK);
        checkOutput("d0_after_valid", 32'(bus8.x_valid), 32'd0);
        checkOutput("d0_after_xout", 32'(bus8.x_out), 32'd0);
        checkOutput("d0_after_last", 32'(bus8.last_bit), 32'd0);

        // Back-to-back A5 then 3C with load_valid held high.
        stream = 16'hA53C;
        applyStimulus(1'b1, 8'hA5);
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (i == 0) applyStimulus(1'b1, 8'h3C);
            if (i == 8) applyStimulus(1'b0, 8'h00);
            checkOutput($sformatf("b2b_bit%0d", i), 32'(bus8.x_out), 32'(stream[15-i]));
            checkOutput($sformatf("b2b_valid%0d", i), 32'(bus8.x_valid), 32'd1);
            checkOutput($sformatf("b2b_last%0d", i), 32'(bus8.last_bit), 32'((i % 8) == 7));
            checkOutput($sformatf("b2b_ready%0d", i), 32'(bus8.load_ready), 32'((i % 8) == 7));
        end
        @(negedge CLK);
        checkOutput("b2b_after_valid", 32'(bus8.x_valid), 32'd0);

        // LSB-first word 8'h0B on the IDLE_BIT=1 lane.
        word = 8'h0B;
        bus_lsb.load_valid = 1'b1;
        bus_lsb.load_data  = word;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (i == 0) bus_lsb.load_valid = 1'b0;
            checkOutput($sformatf("lsb_bit%0d", i), 32'(bus_lsb.x_out), 32'(word[i]));
            checkOutput($sformatf("lsb_valid%0d", i), 32'(bus_lsb.x_valid), 32'd1);
            checkOutput($sformatf("lsb_last%0d", i), 32'(bus_lsb.last_bit), 32'(i == 7));
        end
        @(negedge CLK);
        checkOutput("lsb_after_valid", 32'(bus_lsb.x_valid), 32'd0);
        checkOutput("lsb_after_xout", 32'(bus_lsb.x_out), 32'd1);

        // Competing load while busy must be ignored.
        word     = 8'h96;
        intruder = 8'h5A;
        applyStimulus(1'b1, word);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (i <= 5) applyStimulus(1'b1, intruder);
            else        applyStimulus(1'b0, 8'h00);
            checkOutput($sformatf("busy_bit%0d", i), 32'(bus8.x_out), 32'(word[7-i]));
            if (i >= 1 && i <= 6)
                checkOutput($sformatf("busy_ready%0d", i), 32'(bus8.load_ready), 32'd0);
        end
        @(negedge CLK);
        checkOutput("busy_after_valid", 32'(bus8.x_valid), 32'd0);

        // Reset after three bits of 8'hFF discards the rest of the word.
        applyStimulus(1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (i == 0) applyStimulus(1'b0, 8'h00);
            checkOutput($sformatf("ff_bit%0d", i), 32'(bus8.x_out), 32'd1);
        end
        RESET = 1'b1;
        #1;
        checkOutput("rst_pulse_ready", 32'(bus8.load_ready), 32'd0);
        @(negedge CLK);
        checkOutput("rst_xvalid", 32'(bus8.x_valid), 32'd0);
        checkOutput("rst_xout", 32'(bus8.x_out), 32'd0);
        checkOutput("rst_last", 32'(bus8.last_bit), 32'd0);
        RESET = 1'b0;
        #1;
        checkOutput("rst_release_ready", 32'(bus8.load_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            checkOutput($sformatf("rst_quiet%0d", i), 32'(bus8.x_valid), 32'd0);
        end

        // WIDTH=2 back-to-back 2'b10, 2'b11.
        stream2 = 4'b1011;
        bus2.load_valid = 1'b1;
        bus2.load_data  = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (i == 0) bus2.load_data = 2'b11;
            if (i == 2) bus2.load_valid = 1'b0;
            checkOutput($sformatf("w2_bit%0d", i), 32'(bus2.x_out), 32'(stream2[3-i]));
            checkOutput($sformatf("w2_valid%0d", i), 32'(bus2.x_valid), 32'd1);
            checkOutput($sformatf("w2_last%0d", i), 32'(bus2.last_bit), 32'((i % 2) == 1));
            checkOutput($sformatf("w2_ready%0d", i), 32'(bus2.load_ready), 32'((i % 2) == 1));
        end
        @(negedge CLK);
        checkOutput("w2_after_valid", 32'(bus2.x_valid), 32'd0);
        checkOutput("w2_after_ready", 32'(bus2.load_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
